// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: coin credit accumulation, item vend and change return over valid/ready.
// Optional idle auto-refund is built when VTC_IDLE_REFUND_EN is defined.
`default_nettype none

module vend_txn_ctrl #(
  parameter int                  CREDIT_W       = 8,
  parameter logic [CREDIT_W-1:0] MAX_CREDIT     = 8'd99,
  parameter int                  TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                select_valid,
  input  logic [1:0]          item_select,
  input  logic [CREDIT_W-1:0] price_in,
  input  logic [3:0]          stock_level,
  input  logic                cancel,
  input  logic                vend_ready,
  input  logic                change_ready,
  output logic                vend_valid,
  output logic [1:0]          vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt, w_change_nxt, w_deduct, w_base;
  logic [CREDIT_W:0]   w_sum;
  logic [1:0]          w_item_nxt;
  logic                w_vv_nxt, w_cv_nxt, w_rej_nxt, w_so_nxt, w_ins_nxt;
  logic                w_timeout, w_refund;

`ifdef VTC_IDLE_REFUND_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive quiet IDLE cycle holding credit.
  assign w_timeout = (r_state == S_IDLE) && (credit != '0) &&
                     (r_idle_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if ((r_state != S_IDLE) || (credit == '0) || coin_valid || select_valid || cancel)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_refund = (r_state == S_IDLE) && ((cancel && (credit != '0)) || w_timeout);

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = credit;
    w_change_nxt = change_amount;
    w_item_nxt   = vend_item;
    w_vv_nxt     = vend_valid;
    w_cv_nxt     = change_valid;
    w_rej_nxt    = 1'b0;
    w_so_nxt     = 1'b0;
    w_ins_nxt    = 1'b0;
    w_deduct     = '0;
    w_base       = credit;
    w_sum        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_refund) begin
          w_change_nxt = credit;
          w_credit_nxt = '0;
          w_cv_nxt     = 1'b1;
          w_rej_nxt    = coin_valid;
          w_state_nxt  = S_CHANGE;
        end else begin
          // Selection is judged against the pre-coin credit.
          if (select_valid) begin
            if (stock_level == 4'd0) begin
              w_so_nxt = 1'b1;
            end else if (credit < price_in) begin
              w_ins_nxt = 1'b1;
            end else begin
              w_deduct    = price_in;
              w_item_nxt  = item_select;
              w_vv_nxt    = 1'b1;
              w_state_nxt = S_VEND;
            end
          end
          w_base = credit - w_deduct;
          w_sum  = {1'b0, w_base} + {1'b0, coin_value};
          if (coin_valid && (w_sum > {1'b0, MAX_CREDIT})) begin
            w_rej_nxt    = 1'b1;
            w_credit_nxt = w_base;
          end else if (coin_valid) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
          end else begin
            w_credit_nxt = w_base;
          end
        end
      end
      S_VEND: begin
        w_rej_nxt = coin_valid;
        if (vend_ready) begin
          w_vv_nxt = 1'b0;
          if (credit != '0) begin
            w_change_nxt = credit;
            w_credit_nxt = '0;
            w_cv_nxt     = 1'b1;
            w_state_nxt  = S_CHANGE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        w_rej_nxt = coin_valid;
        if (change_ready) begin
          w_cv_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      vend_valid    <= 1'b0;
      vend_item     <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      credit        <= '0;
      coin_reject   <= 1'b0;
      sold_out      <= 1'b0;
      insufficient  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      vend_valid    <= w_vv_nxt;
      vend_item     <= w_item_nxt;
      change_valid  <= w_cv_nxt;
      change_amount <= w_change_nxt;
      credit        <= w_credit_nxt;
      coin_reject   <= w_rej_nxt;
      sold_out      <= w_so_nxt;
      insufficient  <= w_ins_nxt;
      busy          <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: directed plan scenarios plus random traffic against a behavioural model.
`default_nettype none

module tb_vend_txn_ctrl;

  localparam int T_OUT = 8;
  localparam int MAXC  = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 0, select_valid = 0, cancel = 0, vend_ready = 0, change_ready = 0;
  logic [7:0] coin_value = 0, price_in = 0;
  logic [1:0] item_select = 0;
  logic [3:0] stock_level = 0;
  logic       vend_valid, change_valid, coin_reject, sold_out, insufficient, busy;
  logic [1:0] vend_item;
  logic [7:0] change_amount, credit;

  vend_txn_ctrl #(.CREDIT_W(8), .MAX_CREDIT(8'd99), .TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .select_valid(select_valid), .item_select(item_select),
    .price_in(price_in), .stock_level(stock_level), .cancel(cancel),
    .vend_ready(vend_ready), .change_ready(change_ready),
    .vend_valid(vend_valid), .vend_item(vend_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .credit(credit), .coin_reject(coin_reject), .sold_out(sold_out),
    .insufficient(insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for customer, 1 = vending, 2 = paying change.
  int m_phase, m_credit, m_item, m_camt, m_quiet;
  bit m_vv, m_cv, m_rej, m_so, m_ins;

  function automatic void model_reset();
    m_phase = 0; m_credit = 0; m_item = 0; m_camt = 0; m_quiet = 0;
    m_vv = 0; m_cv = 0; m_rej = 0; m_so = 0; m_ins = 0;
  endfunction

  function automatic void model_step();
    int  c;
    bit  quiet, timed_out;
    c         = m_credit;
    quiet     = !(coin_valid || select_valid || cancel);
    timed_out = 0;
`ifdef VTC_IDLE_REFUND_EN
    timed_out = (m_phase == 0) && (c > 0) && (m_quiet == T_OUT - 1);
    m_quiet   = ((m_phase == 0) && (c > 0) && quiet) ? m_quiet + 1 : 0;
`endif
    m_rej = 0; m_so = 0; m_ins = 0;
    if (m_phase == 0) begin
      if ((cancel && c > 0) || timed_out) begin
        m_camt = c; m_credit = 0; m_cv = 1; m_phase = 2; m_rej = coin_valid;
      end else begin
        if (select_valid) begin
          if (stock_level == 0) m_so = 1;
          else if (c < int'(price_in)) m_ins = 1;
          else begin
            m_item = item_select; c = c - int'(price_in); m_vv = 1; m_phase = 1;
          end
        end
        if (coin_valid) begin
          if (c + int'(coin_value) > MAXC) m_rej = 1;
          else c = c + int'(coin_value);
        end
        m_credit = c;
      end
    end else if (m_phase == 1) begin
      m_rej = coin_valid;
      if (vend_ready) begin
        m_vv = 0;
        if (c > 0) begin m_camt = c; m_credit = 0; m_cv = 1; m_phase = 2; end
        else m_phase = 0;
      end
    end else begin
      m_rej = coin_valid;
      if (change_ready) begin m_cv = 0; m_phase = 0; end
    end
  endfunction

  task automatic compare_all();
    chk("credit", credit, m_credit);
    chk("vend_valid", vend_valid, m_vv);
    chk("vend_item", vend_item, m_item);
    chk("change_valid", change_valid, m_cv);
    chk("change_amount", change_amount, m_camt);
    chk("coin_reject", coin_reject, m_rej);
    chk("sold_out", sold_out, m_so);
    chk("insufficient", insufficient, m_ins);
    chk("busy", busy, m_phase != 0);
  endtask

  task automatic drive(input bit cv, input int cval, input bit sv, input int item,
                       input int price, input int stock, input bit can, input bit vr, input bit cr);
    coin_valid = cv; coin_value = 8'(cval); select_valid = sv; item_select = 2'(item);
    price_in = 8'(price); stock_level = 4'(stock); cancel = can;
    vend_ready = vr; change_ready = cr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet(input int n, input bit vr, input bit cr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, vr, cr);
  endtask

  task automatic coin(input int v);
    drive(1, v, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    coin_valid = 0; select_valid = 0; cancel = 0; vend_ready = 0; change_ready = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_vend_valid", vend_valid, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {coin_reject, sold_out, insufficient}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Normal purchase with stalled dispenser, then change.
    coin(5); coin(5);
    chk("p1_credit10", credit, 10);
    drive(0, 0, 1, 2, 7, 3, 0, 0, 0);
    chk("p1_vend", {vend_valid, vend_item}, {1'b1, 2'd2});
    chk("p1_credit3", credit, 3);
    quiet(3, 0, 0);
    chk("p1_vend_held", vend_valid, 1);
    quiet(1, 1, 0);
    chk("p1_change", {change_valid, change_amount}, {1'b1, 8'd3});
    quiet(1, 0, 1);
    chk("p1_done", {busy, credit}, 0);

    // Refused selections.
    do_reset();
    coin(4);
    drive(0, 0, 1, 1, 6, 5, 0, 0, 0);
    chk("p2_insufficient", {insufficient, busy, credit}, {1'b1, 1'b0, 8'd4});
    quiet(1, 0, 0);
    chk("p2_pulse_one_cycle", insufficient, 0);
    coin(16);
    drive(0, 0, 1, 3, 5, 0, 0, 0, 0);
    chk("p2_sold_out", {sold_out, credit}, {1'b1, 8'd20});

    // Credit ceiling.
    do_reset();
    coin(95); coin(10);
    chk("p3_reject", {coin_reject, credit}, {1'b1, 8'd95});
    coin(4);
    chk("p3_max", {coin_reject, credit}, {1'b0, 8'd99});

    // Cancel wins over coin and select.
    do_reset();
    coin(12);
    drive(1, 5, 1, 1, 3, 2, 1, 0, 0);
    chk("p4_cancel", {change_valid, change_amount, coin_reject, vend_valid, credit},
        {1'b1, 8'd12, 1'b1, 1'b0, 8'd0});
    quiet(1, 0, 1);

    // Select plus coin, coin during VEND, reset mid-transaction.
    do_reset();
    coin(10);
    drive(1, 2, 1, 0, 7, 1, 0, 0, 0);
    chk("p5_vend_credit", {vend_valid, credit}, {1'b1, 8'd5});
    coin(3);
    chk("p5_vend_reject", coin_reject, 1);
    do_reset();

    // Idle refund behaviour.
    coin(6);
    quiet(4, 0, 0);
    coin(1);
`ifdef VTC_IDLE_REFUND_EN
    quiet(7, 0, 0);
    chk("p6_not_yet", busy, 0);
    quiet(1, 0, 0);
    chk("p6_timeout", {change_valid, change_amount}, {1'b1, 8'd7});
    quiet(1, 0, 1);
`else
    quiet(100, 0, 0);
    chk("p6_credit_held", {busy, credit}, {1'b0, 8'd7});
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 30),
            $urandom_range(0, 9) < 2, $urandom_range(0, 3),
            $urandom_range(0, 40), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
